// File: rtl/spi_responder_if.sv
// SPI pin bundle for spi_responder: the master drives SCLK/SS/MOSI,
// and the responder drives MISO and its output enable.
interface spi_responder_if;
    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;
    logic MISO_oe;

    modport master (
        output SCLK,
        output SS,
        output MOSI,
        input  MISO,
        input  MISO_oe
    );

    modport slave (
        input  SCLK,
        input  SS,
        input  MOSI,
        output MISO,
        output MISO_oe
    );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-3 responder with a 64 x 8 register file. A frame is one command
// byte {RW, MS, ADDR[5:0]} followed by data bytes, MSB first.
// Optional feature: define SPI_RESP_RO_PROTECT_EN to make 0x0F and
// 0x28..0x2D read-only from SPI; only the fabric update port can write them.
module spi_responder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h33
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_responder_if.slave spi,
    output logic           wr_valid,
    output logic [5:0]     wr_addr,
    output logic [7:0]     wr_data,
    input  logic           upd_en,
    input  logic [5:0]     upd_addr,
    input  logic [7:0]     upd_data,
    output logic           busy
);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, ss_prev_q;
    // Marks which synchronizer stages (and the edge flop) hold real pin samples.
    logic [SYNC_STAGES:0]   ss_vld_q, ss_vld_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic       rw_q, rw_d;
    logic       ms_q, ms_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       miso_q, miso_d;
    logic       wr_valid_q, wr_valid_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [64];
    logic [7:0] regs_d [64];

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [5:0] addr_nxt;
    logic       ro_hit;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    // A fall only counts once SS has really been seen high, so the reset preset
    // cannot fake a frame start when reset lifts with SS already low.
    assign ss_fall   = ~ss_s & ss_prev_q & ss_vld_q[SYNC_STAGES];
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_shift_q, mosi_s};
    assign addr_nxt  = ms_q ? addr_q + 6'd1 : addr_q;

`ifdef SPI_RESP_RO_PROTECT_EN
    assign ro_hit = (addr_q == 6'h0F) || ((addr_q >= 6'h28) && (addr_q <= 6'h2D));
`else
    assign ro_hit = 1'b0;
`endif

    // Pin synchronizer shift chains.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi.SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
        ss_vld_d    = {ss_vld_q[SYNC_STAGES-1:0], 1'b1};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; SS rising aborts any frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ss_fall) state_d = StCmd;
            StCmd: begin
                if (ss_rise) begin
                    state_d = StIdle;
                end else if (byte_done) begin
                    state_d = StData;
                end
            end
            StData: if (ss_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy        = (state_q != StIdle);
        spi.MISO    = miso_q;
        spi.MISO_oe = ~ss_s;
        wr_valid    = wr_valid_q;
        wr_addr     = wr_addr_q;
        wr_data     = wr_data_q;
    end

    // Shift, command decode, commit/reload and register file next state.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rw_d       = rw_q;
        ms_d       = ms_q;
        addr_d     = addr_q;
        tx_byte_d  = tx_byte_q;
        miso_d     = miso_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        // Fabric update first so a same-address SPI commit below overrides it.
        if (upd_en) regs_d[upd_addr] = upd_data;

        if (state_q == StIdle || ss_rise) begin
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (sclk_rise) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (byte_done) begin
                if (state_q == StCmd) begin
                    rw_d   = rx_byte[7];
                    ms_d   = rx_byte[6];
                    addr_d = rx_byte[5:0];
                    if (rx_byte[7]) tx_byte_d = regs_q[rx_byte[5:0]];
                end else begin
                    addr_d = addr_nxt;
                    if (rw_q) begin
                        tx_byte_d = regs_q[addr_nxt];
                    end else if (!ro_hit) begin
                        regs_d[addr_q] = rx_byte;
                        wr_valid_d     = 1'b1;
                        wr_addr_d      = addr_q;
                        wr_data_d      = rx_byte;
                    end
                end
            end
        end else if (sclk_fall) begin
            miso_d = (state_q == StData && rw_q) ? tx_byte_q[3'd7 - bit_cnt_q] : 1'b0;
        end
    end

    // Datapath and register file flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '1;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            ss_prev_q   <= 1'b1;
            ss_vld_q    <= '0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= 6'd0;
            tx_byte_q   <= 8'd0;
            miso_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= (i == 15) ? WHO_AM_I_VAL : 8'd0;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            ss_vld_q    <= ss_vld_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            tx_byte_q   <= tx_byte_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed frames plus random frames and fabric
// updates, checked against a register-array model of the frame rules.
module tb_spi_responder;

    localparam int SYNC = 2;
    localparam int HALF = 8;  // clk per SCLK phase
`ifdef SPI_RESP_RO_PROTECT_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd_en = 1'b0;
    logic [5:0] upd_addr = 6'd0;
    logic [7:0] upd_data = 8'd0;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    spi_responder_if spi_if ();

    spi_responder #(
        .SYNC_STAGES (SYNC),
        .WHO_AM_I_VAL(8'h33)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi     (spi_if.slave),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .upd_en  (upd_en),
        .upd_addr(upd_addr),
        .upd_data(upd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0]  model [64];
    logic [7:0]  wbuf [8];
    logic [13:0] wr_log [$];

    // Record every committed byte as {addr, data}.
    always @(negedge clk) begin
        if (rst_n && wr_valid) wr_log.push_back({wr_addr, wr_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit tb_ro(input logic [5:0] a);
        return RO_EN && ((a == 6'h0F) || (a >= 6'h28 && a <= 6'h2D));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 8'd0;
        model[15] = 8'h33;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 3: drive MOSI after SCLK falls, sample MISO just before it rises.
    task automatic xfer_bits(input logic [7:0] out, input int nbits, output logic [7:0] rxb);
        rxb = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            spi_if.SCLK = 1'b0;
            spi_if.MOSI = out[7-i];
            wait_clk(HALF);
            rxb[7-i] = spi_if.MISO;
            spi_if.SCLK = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic frame_begin();
        spi_if.SS = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        spi_if.SS = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic fab_upd(input logic [5:0] a, input logic [7:0] d);
        upd_en   = 1'b1;
        upd_addr = a;
        upd_data = d;
        wait_clk(1);
        upd_en = 1'b0;
        model[a] = d;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic ms, input int n);
        logic [7:0] rxb;
        logic [5:0] a;
        a = addr;
        frame_begin();
        xfer_bits({1'b1, ms, addr}, 8, rxb);
        check_eq("busy_mid", 32'(busy), 32'd1);
        check_eq("oe_mid", 32'(spi_if.MISO_oe), 32'd1);
        for (int i = 0; i < n; i++) begin
            xfer_bits(8'($urandom), 8, rxb);
            check_eq("rd_byte", 32'(rxb), 32'(model[a]));
            a = a + {5'd0, ms};
        end
        frame_end();
        check_eq("rd_no_wr", 32'(wr_log.size()), 32'd0);
        check_eq("busy_end", 32'(busy), 32'd0);
        wr_log.delete();
    endtask

    task automatic do_write(input logic [5:0] addr, input logic ms, input int n);
        logic [7:0]  rxb;
        logic [5:0]  a;
        logic [13:0] exp_q [$];
        a = addr;
        frame_begin();
        xfer_bits({1'b0, ms, addr}, 8, rxb);
        check_eq("cmd_miso", 32'(rxb), 32'd0);
        for (int i = 0; i < n; i++) begin
            xfer_bits(wbuf[i], 8, rxb);
            check_eq("wr_miso", 32'(rxb), 32'd0);
            if (!tb_ro(a)) begin
                model[a] = wbuf[i];
                exp_q.push_back({a, wbuf[i]});
            end
            a = a + {5'd0, ms};
        end
        frame_end();
        check_eq("wr_count", 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            check_eq("wr_entry", 32'(wr_log[i]), 32'(exp_q[i]));
        end
        wr_log.delete();
    endtask

    initial begin
        logic [7:0] rxb;
        spi_if.SCLK = 1'b1;
        spi_if.SS   = 1'b1;
        spi_if.MOSI = 1'b0;
        model_reset();

        // Reset state.
        wait_clk(3);
        check_eq("rst_miso", 32'(spi_if.MISO), 32'd0);
        check_eq("rst_oe", 32'(spi_if.MISO_oe), 32'd0);
        check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clk(10);

        // WHO_AM_I read.
        do_read(6'h0F, 1'b0, 1);

        // Single write then read back.
        wbuf[0] = 8'h77;
        do_write(6'h20, 1'b0, 1);
        do_read(6'h20, 1'b0, 1);

        // Fabric-loaded output registers, burst read.
        for (int i = 0; i < 6; i++) fab_upd(6'h28 + 6'(i), 8'h11 * 8'(i + 1));
        do_read(6'h28, 1'b1, 6);

        // Burst write wrapping 0x3F -> 0x00.
        wbuf[0] = 8'hAA;
        wbuf[1] = 8'hBB;
        do_write(6'h3F, 1'b1, 2);
        do_read(6'h3F, 1'b1, 2);

        // Partial byte discarded on SS rise.
        frame_begin();
        xfer_bits(8'h20, 8, rxb);
        xfer_bits(8'hC3, 5, rxb);
        frame_end();
        check_eq("partial_no_wr", 32'(wr_log.size()), 32'd0);
        check_eq("partial_busy", 32'(busy), 32'd0);
        wr_log.delete();
        do_read(6'h20, 1'b0, 1);

        // WHO_AM_I write: blocked only when protection is built in.
        wbuf[0] = 8'h00;
        do_write(6'h0F, 1'b0, 1);
        do_read(6'h0F, 1'b0, 1);

        // Reset mid-frame: no activity until SS goes high and falls again.
        frame_begin();
        xfer_bits(8'h20, 8, rxb);
        xfer_bits(8'hFF, 3, rxb);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        model_reset();
        xfer_bits(8'h55, 8, rxb);
        xfer_bits(8'h66, 8, rxb);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_no_wr", 32'(wr_log.size()), 32'd0);
        frame_end();
        wr_log.delete();
        do_read(6'h20, 1'b0, 1);
        do_read(6'h0F, 1'b0, 1);

        // Random frames and fabric updates.
        for (int it = 0; it < 24; it++) begin
            int unsigned kind;
            int          n;
            logic [5:0]  a;
            logic        ms;
            kind = $urandom_range(0, 2);
            n    = int'($urandom_range(1, 3));
            a    = 6'($urandom_range(0, 63));
            ms   = 1'($urandom);
            if (kind == 0) begin
                fab_upd(a, 8'($urandom));
            end else if (kind == 1) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(a, ms, n);
            end else begin
                do_read(a, ms, n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI slave (responder) holding a 64 x 8 register file.
- Answers the same single-register frame format our SPI master issues to the accelerometer: 8-bit command {RW, MS, ADDR[5:0]}, then one or more data bytes, MSB first.
- Used as an on-FPGA register target for the flight controller and as a sensor stand-in for master bring-up.
- Fabric side: a write-notify strobe, plus an update port that loads sensor/result registers.

Parameters:
- SYNC_STAGES, 2: flops in each pin synchronizer for SCLK, SS and MOSI; minimum 2.
- WHO_AM_I_VAL, 8'h33: reset and fixed value of register 0x0F.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock; idles high.
- SS  input  1  slave select, active low.
- MOSI  input  1  master-to-slave data.
- MISO  output  1  slave-to-master data.
- MISO_oe  output  1  MISO output enable; 1 while SS is low after synchronization.
- wr_valid  output  1  one-clk pulse when an SPI data byte is committed.
- wr_addr  output  6  address of the committed byte.
- wr_data  output  8  value of the committed byte.
- upd_en  input  1  fabric register write enable.
- upd_addr  input  6  fabric write address.
- upd_data  input  8  fabric write data.
- busy  output  1  1 while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - All registers clear to 0, except reg[0x0F]=WHO_AM_I_VAL.
  - MISO=0, MISO_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - State=IDLE, bit_cnt=0, synchronizers preset to SCLK=1, SS=1.
- Timing and edges:
  - SCLK, SS and MOSI pass through SYNC_STAGES flops; edges come from the last stage against one extra flop.
  - Detection latency is SYNC_STAGES+1 clk.
  - SPI mode 3: MOSI is sampled on SCLK rising edges; MISO is updated on SCLK falling edges.
  - Required: SCLK high and low phases each >= SYNC_STAGES+2 clk. The master's 4-clk bit period is below this; it must use >= 8 clk per bit when driving this block.
- State machine:
  - IDLE -> CMD on SS falling edge; bit_cnt=0.
  - CMD: each rising edge shifts MOSI into rx_shift and increments bit_cnt. On the 8th rising edge:
    - latch RW=rx[7], MS=rx[6], addr=rx[5:0]; bit_cnt wraps to 0; go to DATA;
    - if RW=1, tx_byte <= reg[addr].
  - DATA, RW=0 (write): on each 8th rising edge, commit rx_shift to reg[addr] and pulse wr_valid for one clk with wr_addr=addr and wr_data=byte.
  - DATA, RW=1 (read): on each 8th rising edge, tx_byte <= reg[next addr]. This value is a snapshot; later register changes do not affect the byte being shifted.
  - Address advance after each data byte: MS=1 gives addr <= addr+1, wrapping 0x3F -> 0x00; MS=0 keeps addr.
  - SS rising edge in any state: go to IDLE immediately. A partial byte is discarded with no commit and no wr_valid.
- MISO:
  - Every falling edge in DATA with RW=1 sets MISO <= tx_byte[7-bit_cnt].
  - Otherwise MISO is 0 (all of CMD phase, and write frames).
  - MISO_oe follows the synchronized SS inverted.
- Fabric update port: upd_en writes reg[upd_addr] in the same clk, including 0x0F. If an SPI commit hits the same address in the same clk, the SPI commit wins and the update is dropped.
- Reset mid-frame: the frame is abandoned. No further action until SS is seen high and then falls again.
- busy=1 from the clk after SS-fall detection until the clk after SS-rise detection.

Optional Feature:
- SPI_RESP_RO_PROTECT_EN defined: SPI writes to 0x0F and 0x28..0x2D (output data registers) are ignored. Registers stay unchanged and there is no wr_valid pulse; the address still advances. Only upd_en can change those registers.
- Not defined: every address is SPI-writable, including 0x0F.

Test Plan:
- Reset, then read frame 0x8F (RW=1, MS=0, addr 0x0F) + 1 dummy byte -> MISO byte = 0x33; no wr_valid.
- Write frame 0x20 + 0x77 -> one wr_valid pulse with wr_addr=0x20, wr_data=0x77; a follow-up read of 0x20 returns 0x77.
- upd 0x28..0x2D = 0x11..0x66, then burst read cmd 0xE8 + 6 bytes -> MISO 0x11,0x22,0x33,0x44,0x55,0x66.
- Burst write cmd 0x7F (MS=1, addr 0x3F) + 0xAA,0xBB -> reg[0x3F]=0xAA, reg[0x00]=0xBB; two wr_valid pulses with addresses 0x3F then 0x00.
- Write 0x20 + 0xC3, SS raised after 5 data bits -> no wr_valid, reg[0x20] unchanged, busy returns to 0.
- With SPI_RESP_RO_PROTECT_EN, write 0x0F + 0x00 -> reg[0x0F] stays 0x33, no wr_valid. Without the macro -> reg[0x0F]=0x00 and one wr_valid pulse.
